// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor indices, scheduler states.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 5;
    localparam int FLOOR_W_DEF    = 3;

    localparam int FLOOR_S = 0;
    localparam int FLOOR_1 = 1;
    localparam int FLOOR_2 = 2;
    localparam int FLOOR_3 = 3;
    localparam int FLOOR_4 = 4;

    typedef enum logic [2:0] {
        SCHED_IDLE = 3'b001,
        SCHED_UP   = 3'b010,
        SCHED_DOWN = 3'b100
    } sched_state_t;

endpackage

// File: rtl/button_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module button_sync_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches floor call buttons and runs a SCAN scheduler that picks the next target floor.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  moving,
    input  logic                  floor_served,
    output logic [NUM_FLOORS-1:0] req_vector,
    output logic                  req_pending,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  dir_up,
    output logic                  dir_down
);

    logic [NUM_FLOORS-1:0] w_rise;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_req_next;
    logic                  w_in_range;
    logic                  w_above;
    logic                  w_below;
    logic                  w_here;
    logic [FLOOR_W-1:0]    w_low_above;
    logic [FLOOR_W-1:0]    w_high_below;

    logic [NUM_FLOORS-1:0] r_req;
    logic                  r_pending;
    logic [FLOOR_W-1:0]    r_target;
    sched_state_t          r_state;

    function automatic logic [FLOOR_W-1:0] lowest_above(
        input logic [NUM_FLOORS-1:0] req,
        input logic [FLOOR_W-1:0]    cur
    );
        logic [FLOOR_W-1:0] f;
        f = cur;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i > int'(cur) && req[i]) f = FLOOR_W'(i);
        end
        return f;
    endfunction

    function automatic logic [FLOOR_W-1:0] highest_below(
        input logic [NUM_FLOORS-1:0] req,
        input logic [FLOOR_W-1:0]    cur
    );
        logic [FLOOR_W-1:0] f;
        f = cur;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(cur) && req[i]) f = FLOOR_W'(i);
        end
        return f;
    endfunction

    button_sync_edge #(
        .WIDTH (NUM_FLOORS)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (btn),
        .o_rise  (w_rise)
    );

    assign w_in_range = int'(cur_floor) < NUM_FLOORS;
    assign w_clr = (floor_served && w_in_range)
                 ? (NUM_FLOORS'(1) << cur_floor) : '0;
    // Clear beats a same-edge set: the door is already open at that floor.
    assign w_req_next = (r_req | w_rise) & ~w_clr;

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        w_here  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(cur_floor))  w_above = w_above | w_req_next[i];
            if (i < int'(cur_floor))  w_below = w_below | w_req_next[i];
            if (i == int'(cur_floor)) w_here  = w_here  | w_req_next[i];
        end
    end

    assign w_low_above  = lowest_above(w_req_next, cur_floor);
    assign w_high_below = highest_below(w_req_next, cur_floor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req     <= '0;
            r_pending <= 1'b0;
            r_target  <= FLOOR_W'(FLOOR_S);
            r_state   <= SCHED_IDLE;
        end else begin
            r_req     <= w_req_next;
            r_pending <= |w_req_next;
            if (!moving && w_in_range) begin
                unique case (r_state)
                    SCHED_UP: begin
                        if (w_here) begin
                            r_target <= cur_floor;
                        end else if (w_above) begin
                            r_target <= w_low_above;
                        end else if (w_below) begin
                            r_state  <= SCHED_DOWN;
                            r_target <= w_high_below;
                        end else begin
                            r_state  <= SCHED_IDLE;
                            r_target <= cur_floor;
                        end
                    end
                    SCHED_DOWN: begin
                        if (w_here) begin
                            r_target <= cur_floor;
                        end else if (w_below) begin
                            r_target <= w_high_below;
                        end else if (w_above) begin
                            r_state  <= SCHED_UP;
                            r_target <= w_low_above;
                        end else begin
                            r_state  <= SCHED_IDLE;
                            r_target <= cur_floor;
                        end
                    end
                    default: begin
                        if (w_here) begin
                            r_state  <= SCHED_IDLE;
                            r_target <= cur_floor;
                        end else if (w_above) begin
                            r_state  <= SCHED_UP;
                            r_target <= w_low_above;
                        end else if (w_below) begin
                            r_state  <= SCHED_DOWN;
                            r_target <= w_high_below;
                        end else begin
                            r_state  <= SCHED_IDLE;
                            r_target <= cur_floor;
                        end
                    end
                endcase
            end
        end
    end

    assign req_vector   = r_req;
    assign req_pending  = r_pending;
    assign target_floor = r_target;
    assign dir_up       = (r_state == SCHED_UP);
    assign dir_down     = (r_state == SCHED_DOWN);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scenario bench for floor_request_scheduler with a queue of expected output words.
module tb_floor_request_scheduler;

    logic       clk;
    logic       reset;
    logic [4:0] btn;
    logic [2:0] cur_floor;
    logic       moving;
    logic       floor_served;
    logic [4:0] req_vector;
    logic       req_pending;
    logic [2:0] target_floor;
    logic       dir_up;
    logic       dir_down;

    floor_request_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .cur_floor    (cur_floor),
        .moving       (moving),
        .floor_served (floor_served),
        .req_vector   (req_vector),
        .req_pending  (req_pending),
        .target_floor (target_floor),
        .dir_up       (dir_up),
        .dir_down     (dir_down)
    );

    typedef struct packed {
        logic [4:0]  btn;
        logic [2:0]  cur;
        logic        mov;
        logic        srv;
        logic [10:0] exp;
    } step_t;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [10:0] sb[$];
    logic [10:0] w_obs;

    assign w_obs = {req_vector, req_pending, target_floor, dir_up, dir_down};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic [4:0] r, input logic p,
                                       input logic [2:0] t, input logic u,
                                       input logic d);
        return {r, p, t, u, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 1'b0;
            sb.push_back(ex(5'b0, 1'b0, 3'd0, 1'b0, 1'b0));
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_latency();
        step_t       st[$];
        logic [10:0] e;
        st.push_back({5'b01000, 3'd0, 1'b0, 1'b0, ex(5'b0, 0, 3'd0, 0, 0)});
        st.push_back({5'b01000, 3'd0, 1'b0, 1'b0, ex(5'b0, 0, 3'd0, 0, 0)});
        st.push_back({5'b01000, 3'd0, 1'b0, 1'b0, ex(5'b01000, 1, 3'd3, 1, 0)});
        st.push_back({5'b01000, 3'd0, 1'b0, 1'b0, ex(5'b01000, 1, 3'd3, 1, 0)});
        st.push_back({5'b01000, 3'd3, 1'b0, 1'b1, ex(5'b0, 0, 3'd3, 0, 0)});
        st.push_back({5'b01000, 3'd3, 1'b0, 1'b0, ex(5'b0, 0, 3'd3, 0, 0)});
        st.push_back({5'b01000, 3'd3, 1'b0, 1'b0, ex(5'b0, 0, 3'd3, 0, 0)});
        st.push_back({5'b01000, 3'd3, 1'b0, 1'b0, ex(5'b0, 0, 3'd3, 0, 0)});
        st.push_back({5'b00000, 3'd3, 1'b0, 1'b0, ex(5'b0, 0, 3'd3, 0, 0)});
        foreach (st[i]) begin
            btn = st[i].btn; cur_floor = st[i].cur;
            moving = st[i].mov; floor_served = st[i].srv;
            sb.push_back(st[i].exp);
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL latency step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_nearest_above();
        step_t       st[$];
        logic [10:0] e;
        st.push_back({5'b11000, 3'd1, 1'b0, 1'b0, ex(5'b0, 0, 3'd1, 0, 0)});
        st.push_back({5'b00000, 3'd1, 1'b0, 1'b0, ex(5'b0, 0, 3'd1, 0, 0)});
        st.push_back({5'b00000, 3'd1, 1'b0, 1'b0, ex(5'b11000, 1, 3'd3, 1, 0)});
        st.push_back({5'b00000, 3'd2, 1'b1, 1'b0, ex(5'b11000, 1, 3'd3, 1, 0)});
        st.push_back({5'b00000, 3'd3, 1'b0, 1'b1, ex(5'b10000, 1, 3'd4, 1, 0)});
        foreach (st[i]) begin
            btn = st[i].btn; cur_floor = st[i].cur;
            moving = st[i].mov; floor_served = st[i].srv;
            sb.push_back(st[i].exp);
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL nearest_above step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_reversal();
        step_t       st[$];
        logic [10:0] e;
        st.push_back({5'b00101, 3'd4, 1'b1, 1'b0, ex(5'b10000, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd4, 1'b1, 1'b0, ex(5'b10000, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd4, 1'b1, 1'b0, ex(5'b10101, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd4, 1'b0, 1'b1, ex(5'b00101, 1, 3'd2, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b1, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd0, 1'b0, 1'b1, ex(5'b00000, 0, 3'd0, 0, 0)});
        foreach (st[i]) begin
            btn = st[i].btn; cur_floor = st[i].cur;
            moving = st[i].mov; floor_served = st[i].srv;
            sb.push_back(st[i].exp);
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL reversal step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_freeze();
        step_t       st[$];
        logic [10:0] e;
        st.push_back({5'b10000, 3'd2, 1'b0, 1'b0, ex(5'b0, 0, 3'd2, 0, 0)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b0, 0, 3'd2, 0, 0)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b10000, 1, 3'd4, 1, 0)});
        st.push_back({5'b00001, 3'd2, 1'b1, 1'b0, ex(5'b10000, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd2, 1'b1, 1'b0, ex(5'b10000, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd2, 1'b1, 1'b0, ex(5'b10001, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd4, 1'b1, 1'b1, ex(5'b00001, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd2, 1'b1, 1'b0, ex(5'b00001, 1, 3'd4, 1, 0)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        foreach (st[i]) begin
            btn = st[i].btn; cur_floor = st[i].cur;
            moving = st[i].mov; floor_served = st[i].srv;
            sb.push_back(st[i].exp);
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL freeze step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_collision();
        step_t       st[$];
        logic [10:0] e;
        st.push_back({5'b00100, 3'd2, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b00101, 1, 3'd2, 0, 1)});
        st.push_back({5'b00100, 3'd2, 1'b0, 1'b0, ex(5'b00101, 1, 3'd2, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b00101, 1, 3'd2, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b1, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd2, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        foreach (st[i]) begin
            btn = st[i].btn; cur_floor = st[i].cur;
            moving = st[i].mov; floor_served = st[i].srv;
            sb.push_back(st[i].exp);
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL collision step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        step_t       st[$];
        logic [10:0] e;
        st.push_back({5'b00000, 3'd7, 1'b0, 1'b1, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b11010, 3'd7, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd7, 1'b0, 1'b0, ex(5'b00001, 1, 3'd0, 0, 1)});
        st.push_back({5'b00000, 3'd7, 1'b0, 1'b0, ex(5'b11011, 1, 3'd0, 0, 1)});
        foreach (st[i]) begin
            btn = st[i].btn; cur_floor = st[i].cur;
            moving = st[i].mov; floor_served = st[i].srv;
            sb.push_back(st[i].exp);
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL out_of_range step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        #3;
        reset = 1'b1;
        sb.push_back(ex(5'b0, 1'b0, 3'd0, 1'b0, 1'b0));
        #1;
        e = sb.pop_front();
        n_run++;
        if (w_obs !== e) begin
            n_fail++;
            $display("FAIL async_reset immediate: got %b want %b", w_obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) btn = 5'b00010;
            if (i == 2) begin
                btn   = 5'b00000;
                reset = 1'b0;
            end
            sb.push_back(ex(5'b0, 1'b0, 3'd0, 1'b0, 1'b0));
            tick();
            e = sb.pop_front();
            n_run++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL async_reset step %0d: got %b want %b", i, w_obs, e);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        btn          = '0;
        cur_floor    = '0;
        moving       = 1'b0;
        floor_served = 1'b0;
        test_reset();
        test_latency();
        test_nearest_above();
        test_reversal();
        test_freeze();
        test_collision();
        test_out_of_range();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
